// File: rtl/edge_meas_pkg.sv
// Shared types and default parameters for the edge period meter.
package edge_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } state_t;

  localparam int NOMINAL_PERIOD = 12500;  // 8 kHz at 100 MHz
  localparam int DEF_CNT_W      = 24;
  localparam int DEF_TIMEOUT    = 25000;
  localparam int DEF_AVG_LOG2   = 3;

endpackage

// File: rtl/edge_period_meter_if.sv
// Control and result bundle between the edge period meter and its consumer.
interface edge_period_meter_if
  import edge_meas_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             enable;
  logic             edge_in;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic [CNT_W-1:0] avg_period;
  logic             avg_vld;
  logic             timeout;

  modport master (
    output enable, edge_in,
    input  period, period_vld, avg_period, avg_vld, timeout
  );

  modport slave (
    input  enable, edge_in,
    output period, period_vld, avg_period, avg_vld, timeout
  );

endinterface

// File: rtl/period_avg.sv
// Non-sliding block average of 2^AVG_LOG2 periods; avg_vld is registered so it
// lines up with the registered period strobe in the parent.
module period_avg
  import edge_meas_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [CNT_W-1:0] period,
  input  logic             period_vld,
  input  logic             clear,
  output logic [CNT_W-1:0] avg_period,
  output logic             avg_vld
);

  localparam int ACC_W = CNT_W + AVG_LOG2;

  logic [ACC_W-1:0]    r_acc;
  logic [AVG_LOG2-1:0] r_cnt;
  logic [CNT_W-1:0]    r_avg;
  logic                r_avg_vld;
  logic [ACC_W-1:0]    w_sum;
  logic                w_last;

  assign w_sum  = r_acc + ACC_W'(period);
  assign w_last = (r_cnt == {AVG_LOG2{1'b1}});

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_avg     <= '0;
      r_avg_vld <= 1'b0;
    end else begin
      r_avg_vld <= 1'b0;
      if (clear) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (period_vld) begin
        if (w_last) begin
          r_avg     <= w_sum[ACC_W-1:AVG_LOG2];
          r_avg_vld <= 1'b1;
          r_acc     <= '0;
          r_cnt     <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + AVG_LOG2'(1);
        end
      end
    end
  end

  assign avg_period = r_avg;
  assign avg_vld    = r_avg_vld;

endmodule

// File: rtl/edge_period_meter.sv
// Measures sys_clk cycles between edge pulses, averages them and flags loss of signal.
//   state   | meaning
//   IDLE    | waiting for the first edge after reset or enable
//   MEASURE | counting cycles between edges
//   LOST    | timeout declared, next edge re-arms
module edge_period_meter
  import edge_meas_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  edge_period_meter_if.slave bus
);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_period_vld;
  logic             r_timeout;
  logic             w_edge;
  logic             w_tc;
  logic             w_load;
  logic             w_lose;
  logic [CNT_W-1:0] w_period_next;

  // An edge only counts while enabled, so an edge in the cycle enable falls is dropped.
  assign w_edge        = bus.enable & bus.edge_in;
  assign w_tc          = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_period_next = r_cnt + CNT_W'(1);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (!bus.enable) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_edge) w_next_state = MEASURE;
        MEASURE: if (!w_edge && w_tc) w_next_state = LOST;
        LOST:    if (w_edge) w_next_state = MEASURE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Edge wins over the terminal count when both land in the same cycle.
  always_comb begin
    w_load = 1'b0;
    w_lose = 1'b0;
    if (r_state == MEASURE) begin
      w_load = w_edge;
      w_lose = bus.enable & ~w_edge & w_tc;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_cnt        <= '0;
      r_period     <= '0;
      r_period_vld <= 1'b0;
      r_timeout    <= 1'b0;
    end else if (!bus.enable) begin
      r_cnt        <= '0;
      r_period_vld <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_period_vld <= w_load;
      if (w_load) r_period <= w_period_next;
      if (w_lose)      r_timeout <= 1'b1;
      else if (w_load) r_timeout <= 1'b0;
      if (w_edge || w_lose || r_state != MEASURE) r_cnt <= '0;
      else                                        r_cnt <= w_period_next;
    end
  end

  period_avg #(
    .CNT_W   (CNT_W),
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .period    (w_period_next),
    .period_vld(w_load),
    .clear     (w_lose | ~bus.enable),
    .avg_period(bus.avg_period),
    .avg_vld   (bus.avg_vld)
  );

  assign bus.period     = r_period;
  assign bus.period_vld = r_period_vld;
  assign bus.timeout    = r_timeout;

endmodule

// File: tb/tb_edge_period_meter.sv
// Bench for edge_period_meter with timing scaled by 1/100 (nominal period 125, timeout 250).
module tb_edge_period_meter;

  localparam int CW   = 16;
  localparam int NOM  = edge_meas_pkg::NOMINAL_PERIOD / 100;
  localparam int TO   = 2 * NOM;
  localparam int AL   = 3;
  localparam int NAVG = 1 << AL;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;

  edge_period_meter_if #(.CNT_W(CW)) bus ();

  edge_period_meter #(
    .CNT_W   (CW),
    .TIMEOUT (TO),
    .AVG_LOG2(AL)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: time-stamps edges and keeps the averaging window as a queue.
  int  t = 0;
  int  last_t = 0;
  bit  armed = 1'b0;
  int  win[$];
  int  exp_p = 0, exp_avg = 0;
  bit  exp_pv = 1'b0, exp_av = 1'b0, exp_to = 1'b0;

  initial begin
    forever begin
      @(posedge sys_clk or negedge sys_rst);
      if (!sys_rst) begin
        armed = 1'b0; win.delete();
        exp_p = 0; exp_avg = 0; exp_pv = 1'b0; exp_av = 1'b0; exp_to = 1'b0;
      end else begin
        t++;
        exp_pv = 1'b0;
        exp_av = 1'b0;
        if (!bus.enable) begin
          armed = 1'b0; exp_to = 1'b0; win.delete();
        end else if (bus.edge_in) begin
          if (armed) begin
            exp_p = t - last_t;
            exp_pv = 1'b1;
            exp_to = 1'b0;
            win.push_back(exp_p);
            if (win.size() == NAVG) begin
              int s;
              s = 0;
              foreach (win[k]) s += win[k];
              exp_avg = s / NAVG;
              exp_av = 1'b1;
              win.delete();
            end
          end
          armed = 1'b1;
          last_t = t;
        end else if (armed && (t - last_t) == TO) begin
          armed = 1'b0; exp_to = 1'b1; win.delete();
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_rst && cmp_en) begin
        chk("period",     bus.period,     exp_p);
        chk("period_vld", bus.period_vld, exp_pv);
        chk("avg_period", bus.avg_period, exp_avg);
        chk("avg_vld",    bus.avg_vld,    exp_av);
        chk("timeout",    bus.timeout,    exp_to);
      end
    end
  end

  task automatic cyc(input bit e);
    bus.edge_in = e;
    @(negedge sys_clk);
    bus.edge_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0);
  endtask

  task automatic space(input int n);
    idle(n - 1);
    cyc(1'b1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_period"}, bus.period, 0);
    chk({nm, "_pv"},     bus.period_vld, 0);
    chk({nm, "_avg"},    bus.avg_period, 0);
    chk({nm, "_av"},     bus.avg_vld, 0);
    chk({nm, "_to"},     bus.timeout, 0);
  endtask

  task automatic run_nominal(input string nm);
    cyc(1'b1);
    chk({nm, "_first_pv"}, bus.period_vld, 0);
    for (int i = 1; i <= NAVG; i++) begin
      space(NOM);
      chk({nm, "_pv"}, bus.period_vld, 1);
      chk({nm, "_period"}, bus.period, NOM);
      chk({nm, "_av"}, bus.avg_vld, (i == NAVG) ? 1 : 0);
    end
    chk({nm, "_avg"}, bus.avg_period, NOM);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable  = 1'b0;
    bus.edge_in = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk_all_zero("reset");
    sys_rst = 1'b1;
    bus.enable = 1'b1;
    cmp_en = 1'b1;
    idle(7);

    // 1: nominal 8 kHz stream
    run_nominal("s1");

    // 2: edges stop after three periods
    repeat (3) space(NOM);
    idle(TO - 1);
    chk("s2_to_early", bus.timeout, 0);
    idle(1);
    chk("s2_to_set", bus.timeout, 1);
    chk("s2_period_hold", bus.period, NOM);
    idle(40);
    cyc(1'b1);
    chk("s2_rearm_pv", bus.period_vld, 0);
    chk("s2_rearm_to", bus.timeout, 1);
    space(NOM);
    chk("s2_pv", bus.period_vld, 1);
    chk("s2_to_clr", bus.timeout, 0);
    for (int i = 2; i <= NAVG; i++) begin
      space(NOM);
      chk("s2_av", bus.avg_vld, (i == NAVG) ? 1 : 0);
    end

    // 3: spacing at and beyond the timeout
    space(TO);
    chk("s3_period_to", bus.period, TO);
    chk("s3_pv_to", bus.period_vld, 1);
    chk("s3_to_clear", bus.timeout, 0);
    idle(TO);
    chk("s3_to_set", bus.timeout, 1);
    cyc(1'b1);
    chk("s3_late_pv", bus.period_vld, 0);

    // 4: back-to-back edges, then an alternating window
    space(1);
    chk("s4_p1", bus.period, 1);
    chk("s4_to_clr", bus.timeout, 0);
    space(2);
    chk("s4_p2", bus.period, 2);
    bus.enable = 1'b0;
    cyc(1'b0);
    bus.enable = 1'b1;
    cyc(1'b1);
    for (int i = 0; i < NAVG; i++) space((i % 2 == 0) ? NOM - 5 : NOM + 5);
    chk("s4_av", bus.avg_vld, 1);
    chk("s4_avg", bus.avg_period, NOM);

    // 5: enable dropped mid-count with a coincident edge
    idle(60);
    bus.enable = 1'b0;
    cyc(1'b1);
    chk("s5_pv_low", bus.period_vld, 0);
    chk("s5_period_hold", bus.period, NOM + 5);
    chk("s5_avg_hold", bus.avg_period, NOM);
    idle(30);
    bus.enable = 1'b1;
    cyc(1'b1);
    chk("s5_first_pv", bus.period_vld, 0);
    space(NOM);
    chk("s5_period", bus.period, NOM);

    // 6: asynchronous reset pulse mid-measurement
    space(NOM);
    idle(50);
    @(posedge sys_clk);
    #3 sys_rst = 1'b0;
    #1 chk_all_zero("s6_async");
    repeat (3) @(posedge sys_clk);
    #2 sys_rst = 1'b1;
    @(negedge sys_clk);
    idle(5);
    run_nominal("s6");

    // Random traffic with occasional enable drops and timeouts
    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        bus.enable = 1'b0;
        repeat ($urandom_range(1, 5)) cyc(1'($urandom_range(0, 1)));
        bus.enable = 1'b1;
      end else if (r == 1) begin
        space(TO + $urandom_range(1, 20));
      end else if (r == 2) begin
        space(TO);
      end else begin
        space($urandom_range(1, TO));
      end
    end
    idle(5);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/edge_period_meter.md
Name: edge_period_meter

Overview:
- Sits directly downstream of edge_check_top and consumes its single-cycle edge pulses (signal_out), here on port edge_in.
- Counts sys_clk cycles (100 MHz) between consecutive edge pulses and reports the instantaneous period with a valid strobe.
- Reports a running average over 2^AVG_LOG2 periods.
- Flags loss of signal when no edge arrives within TIMEOUT cycles; nominal 8 kHz input gives a period of 12500 cycles.

Parameters:
- CNT_W, 24, width of period counter and period outputs; must satisfy TIMEOUT < 2^CNT_W.
- TIMEOUT, 25000, cycles without an edge before loss-of-signal is declared (2x nominal period).
- AVG_LOG2, 3, log2 of the number of periods averaged (8).

Ports:
- sys_clk  in  1  system clock, 100 MHz
- sys_rst  in  1  reset, asynchronous, active-low
- enable  in  1  measurement enable, synchronous
- edge_in  in  1  single-cycle edge pulse from edge_check_top
- period  out  CNT_W  last measured period in sys_clk cycles
- period_vld  out  1  one-cycle strobe, period updated
- avg_period  out  CNT_W  average of last 2^AVG_LOG2 periods
- avg_vld  out  1  one-cycle strobe, avg_period updated
- timeout  out  1  level, loss of signal

Behaviour:
- Reset (sys_rst=0, asynchronous): state=IDLE, counter=0, accumulator=0, sample count=0; all outputs 0.
- States:
  - IDLE: waiting for the first edge after reset or enable.
  - MEASURE: counting cycles between edges.
  - LOST: timeout declared; waiting for the next edge to re-arm.
- IDLE: edge_in=1 and enable=1 -> MEASURE, counter=0; no period_vld.
- MEASURE, counter increments every cycle.
  - On edge_in=1: period=counter+1, period_vld=1 in the next cycle (1-cycle latency), counter=0, stay in MEASURE.
  - Example: edges at cycles 0 and 12500 -> period=12500.
- Back-to-back edges (consecutive cycles) -> period=1. The counter never exceeds TIMEOUT-1, so no wrap is possible.
- Timeout: in MEASURE, with no edge and counter+1==TIMEOUT -> timeout=1 next cycle, state=LOST, accumulator and sample count cleared; period and avg_period hold their last values.
- Simultaneous edge and timeout condition: the edge wins -> period=TIMEOUT reported valid, no timeout.
- LOST: edge_in=1 -> MEASURE, counter=0; no period_vld. timeout stays 1 until the first subsequent period_vld, and clears in the same cycle that strobe asserts.
- Averaging:
  - Each valid period is added to a (CNT_W+AVG_LOG2)-bit accumulator and the sample count increments.
  - On the 2^AVG_LOG2-th sample: avg_period = sum >> AVG_LOG2 (truncating), avg_vld=1 in the same cycle as that period_vld; accumulator and count restart at 0.
  - The average window is non-sliding.
- enable=0, synchronous:
  - state=IDLE; counter, accumulator and count cleared; timeout cleared.
  - period and avg_period hold their values; strobes are 0; edge_in is ignored.
  - An edge in the same cycle that enable falls is ignored.
- Reset asserted mid-measurement: all state and outputs return to reset values immediately, with no strobes. After release the block waits in IDLE for a fresh first edge.

Decomposition:
- Package edge_meas_pkg:
  - state enum (IDLE, MEASURE, LOST).
  - Constants NOMINAL_PERIOD=12500 and default CNT_W/TIMEOUT/AVG_LOG2.
- One sub-module: period_avg. It holds the accumulator, sample counter and shift, with inputs period/period_vld/clear and outputs avg_period/avg_vld.

Test Plan:
1. Reset release, then an 8 kHz square into edge_check_top (edge every 12500 cycles) -> first edge gives no strobe; each subsequent edge gives period=12500, period_vld 1 cycle after edge_in; after 8 periods, avg_period=12500 with avg_vld coincident with the 8th period_vld.
2. Edges stop after 3 valid periods -> timeout=1 exactly 25000 cycles after the last edge (+1 cycle registration); period holds 12500; on restart, the first edge gives no strobe; the second edge gives period=12500 and timeout=0 that cycle; the average restarts and needs 8 new samples.
3. Edge spacing exactly 25000 cycles -> period=25000 valid, timeout stays 0; spacing 25001 -> timeout=1, no period_vld.
4. Edges at cycles 0, 1, 3 -> period=1 then period=2; alternating periods 12000/13000 for 8 samples -> avg_period=12500.
5. enable dropped mid-count, then raised -> no strobes while low, outputs held; first edge after re-enable gives no strobe; the next gives the correct period.
6. sys_rst pulsed low for 3 cycles mid-measurement, asynchronous to sys_clk -> all outputs 0 immediately; after release, behaviour matches scenario 1 from IDLE.
